seg7_scan_driver: RTL and testbench

//  Time-multiplexed N-digit 7-segment driver; generalises the fixed 2-digit LED interface.

---
 rtl/seg7_scan_driver_if.sv | 19 +
 rtl/seg7_scan_driver.sv | 136 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Host-side bus of seg7_scan_driver: digit values, blank mask, load strobe and busy flag.
// The per-digit decimal point input only exists when SEG7_DP_EN is defined.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
) ();
    logic [4*NUM_DIGITS-1:0] digit_data;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    load;
    logic                    busy;
`ifdef SEG7_DP_EN
    logic [NUM_DIGITS-1:0]   dp_in;

    modport master (output digit_data, digit_en, load, dp_in, input busy);
    modport slave  (input digit_data, digit_en, load, dp_in, output busy);
`else
    modport master (output digit_data, digit_en, load, input busy);
    modport slave  (input digit_data, digit_en, load, output busy);
`endif
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with frame-synchronous double buffering.
// Optional decimal point support is enabled by defining SEG7_DP_EN.
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    seg7_scan_driver_if.slave     bus,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [6:0]            cathode
`ifdef SEG7_DP_EN
    ,
    output logic                  dp
`endif
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic          POL        = (ACTIVE_LOW != 0);

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    // Assertion is asynchronous; release is re-timed to the clock through two flops.
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_int_n = rst_sync[1];

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic                    tick;
    logic                    frame_end;
    logic [4*NUM_DIGITS-1:0] pending;
    logic [4*NUM_DIGITS-1:0] display;
    logic                    busy_r;

    assign tick      = (presc == PRESC_LAST);
    assign frame_end = tick && (idx == IDX_LAST);
    assign bus.busy  = busy_r;

    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

    // A load on the frame boundary still hands the older pending value to display.
    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            pending <= '0;
            display <= '0;
            busy_r  <= 1'b0;
        end else begin
            if (bus.load) pending <= bus.digit_data;
            if (frame_end && busy_r) display <= pending;
            if (bus.load)       busy_r <= 1'b1;
            else if (frame_end) busy_r <= 1'b0;
        end
    end

    logic [NUM_DIGITS-1:0] anode_nxt;
    logic [6:0]            seg_nxt;
    logic [3:0]            nibble;
`ifdef SEG7_DP_EN
    logic                  dp_nxt;
`endif

    always_comb begin
        anode_nxt = '0;
        seg_nxt   = '0;
        nibble    = display[4*idx +: 4];
`ifdef SEG7_DP_EN
        dp_nxt    = 1'b0;
`endif
        if (presc >= BLANK_END) begin
            anode_nxt[idx] = 1'b1;
            if (bus.digit_en[idx]) begin
                seg_nxt = seg_decode(nibble);
`ifdef SEG7_DP_EN
                dp_nxt  = bus.dp_in[idx];
`endif
            end
        end
    end

    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            anode   <= {NUM_DIGITS{POL}};
            cathode <= {7{POL}};
`ifdef SEG7_DP_EN
            dp      <= POL;
`endif
        end else begin
            anode   <= anode_nxt ^ {NUM_DIGITS{POL}};
            cathode <= seg_nxt ^ {7{POL}};
`ifdef SEG7_DP_EN
            dp      <= dp_nxt ^ POL;
`endif
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 8-cycle slots, 2 blank cycles, active-low pins.
module tb_seg7_scan_driver;
    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] anode;
    logic [6:0] cathode;
`ifdef SEG7_DP_EN
    logic       dp;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int multi_bad = 0;

    seg7_scan_driver_if #(.NUM_DIGITS(4)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2),
        .ACTIVE_LOW  (1)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus.slave),
        .anode  (anode),
        .cathode(cathode)
`ifdef SEG7_DP_EN
        ,
        .dp     (dp)
`endif
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if ($countones(~anode) > 1) multi_bad++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_anode(input logic [3:0] target, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clock);
            if (anode === target) found = 1'b1;
        end
        check_eq({tag, "_seen"}, 32'(found), 32'd1);
    endtask

    task automatic wait_busy_low(input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clock);
            if (bus.busy === 1'b0) found = 1'b1;
        end
        check_eq({tag, "_busy_low"}, 32'(found), 32'd1);
    endtask

    task automatic do_load(input logic [15:0] data);
        bus.digit_data = data;
        bus.load       = 1'b1;
        @(negedge clock);
        bus.load       = 1'b0;
    endtask

    // Negedges from reset release to first non-blank anode: 2 synchroniser cycles,
    // then slot 0 blank (presc 0,1) and registered output of presc 2.
    task automatic first_active(output int lat);
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clock);
            if (anode !== 4'b1111) lat = i;
        end
    endtask

    task automatic run_len(input logic [3:0] value, output int n);
        n = 0;
        while (anode === value && n < 20) begin
            n++;
            @(negedge clock);
        end
    endtask

    int lat;
    int rl;

    initial begin
        bus.digit_data = '0;
        bus.digit_en   = 4'b1111;
        bus.load       = 1'b0;
`ifdef SEG7_DP_EN
        bus.dp_in      = 4'b0000;
`endif
        // 1: reset state and first digit after release
        repeat (3) @(negedge clock);
        check_eq("rst_anode", 32'(anode), 32'hF);
        check_eq("rst_cathode", 32'(cathode), 32'h7F);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
`ifdef SEG7_DP_EN
        check_eq("rst_dp", 32'(dp), 32'd1);
`endif
        reset_n = 1'b1;
        first_active(lat);
        check_eq("rst_latency", 32'(lat), 32'd5);
        check_eq("rst_first_anode", 32'(anode), 32'hE);
        check_eq("rst_first_cathode", 32'(cathode), 32'b0000001);

        // 2: buffered load shown from the next frame
        do_load(16'h1A3F);
        check_eq("load_busy", 32'(bus.busy), 32'd1);
        wait_busy_low("load");
        wait_anode(4'b1110, "load_d0");
        check_eq("load_d0_F", 32'(cathode), 32'b0111000);
        wait_anode(4'b1101, "load_d1");
        check_eq("load_d1_3", 32'(cathode), 32'b0000110);
        wait_anode(4'b1011, "load_d2");
        check_eq("load_d2_A", 32'(cathode), 32'b0001000);
        wait_anode(4'b0111, "load_d3");
        check_eq("load_d3_1", 32'(cathode), 32'b1001111);

        // 3: scan order and slot timing
        wait_anode(4'b1110, "scan_start");
        for (int d = 0; d < 4; d++) begin
            run_len(~(4'b0001 << d), rl);
            check_eq($sformatf("scan_active_d%0d", d), 32'(rl), 32'd6);
            run_len(4'b1111, rl);
            check_eq($sformatf("scan_blank_d%0d", d), 32'(rl), 32'd2);
        end

        // 4a: two loads in one frame, only the last one is shown
        wait_anode(4'b1110, "dbl_start");
        do_load(16'h1111);
        @(negedge clock);
        do_load(16'h2222);
        wait_busy_low("dbl");
        wait_anode(4'b1110, "dbl_d0");
        check_eq("dbl_d0_2", 32'(cathode), 32'b0010010);
        wait_anode(4'b0111, "dbl_d3");
        check_eq("dbl_d3_2", 32'(cathode), 32'b0010010);

        // 4b: load on the frame-boundary cycle
        wait_anode(4'b1110, "bnd_start");
        do_load(16'h4444);
        wait_anode(4'b0111, "bnd_d3");
        repeat (4) @(negedge clock);
        do_load(16'h3333);
        check_eq("bnd_busy_held", 32'(bus.busy), 32'd1);
        wait_anode(4'b1110, "bnd_old");
        check_eq("bnd_old_4", 32'(cathode), 32'b1001100);
        wait_busy_low("bnd");
        wait_anode(4'b1110, "bnd_new");
        check_eq("bnd_new_3", 32'(cathode), 32'b0000110);

        // 5: per-digit blank mask
        bus.digit_en = 4'b0101;
        wait_anode(4'b1101, "en_d1");
        check_eq("en_d1_off", 32'(cathode), 32'h7F);
        wait_anode(4'b0111, "en_d3");
        check_eq("en_d3_off", 32'(cathode), 32'h7F);
        wait_anode(4'b1110, "en_d0");
        check_eq("en_d0_on", 32'(cathode), 32'b0000110);
        wait_anode(4'b1011, "en_d2");
        check_eq("en_d2_on", 32'(cathode), 32'b0000110);

        // 6: reset mid-slot 2
        bus.digit_en = 4'b1111;
`ifdef SEG7_DP_EN
        bus.dp_in    = 4'b0010;
`endif
        wait_anode(4'b1011, "mid_d2");
        repeat (2) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_anode", 32'(anode), 32'hF);
        check_eq("mid_rst_cathode", 32'(cathode), 32'h7F);
        @(negedge clock);
        reset_n = 1'b1;
        first_active(lat);
        check_eq("mid_latency", 32'(lat), 32'd5);
        check_eq("mid_anode_idx0", 32'(anode), 32'hE);
        check_eq("mid_display_0", 32'(cathode), 32'b0000001);
        check_eq("mid_busy", 32'(bus.busy), 32'd0);
`ifdef SEG7_DP_EN
        check_eq("dp_d0_off", 32'(dp), 32'd1);
        wait_anode(4'b1101, "dp_d1");
        check_eq("dp_d1_on", 32'(dp), 32'd0);
        wait_anode(4'b1111, "dp_blank");
        check_eq("dp_blank_off", 32'(dp), 32'd1);
`endif
        check_eq("multi_anode", 32'(multi_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
